ysyx_23060191_isram_resp: RTL and testbench

- Instruction-memory responder at the far end of the fetch path.
- Accepts one fetch address per transaction from the PC/fetch side over a valid/ready request channel.
- Reads a word from an internal instruction array after a fixed, parameterised latency and returns it with a response code over a valid/ready response channel.
- Also provides a program-load write port and a wrapping count of accepted fetches for the testbench and performance counters.

---
 rtl/ysyx_23060191_isram_resp_if.sv | 25 ++
 rtl/ysyx_23060191_isram_resp.sv | 133 +++++++++++++
 tb/tb_ysyx_23060191_isram_resp.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060191_isram_resp_if.sv
// ysyx_23060191_isram_resp_if
//   Fetch request/response channel between the PC/fetch side (master) and
//   the instruction-memory responder (slave).
//   Request : arvalid/arready handshake carrying araddr (byte address, the pc).
//   Response: rvalid/rready handshake carrying rdata and rresp
//             (00 OK, 10 misaligned, 11 out of range).
interface ysyx_23060191_isram_resp_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_23060191_isram_resp.sv
// ysyx_23060191_isram_resp
//   Instruction-memory responder. Accepts one fetch address at a time,
//   waits LATENCY cycles, then returns the addressed word (or an error code)
//   and holds it until the consumer takes it.
// Ports:
//   clk        clock
//   rstn       synchronous active-low reset
//   bus        slave side of the fetch channel (ar*/r* signals)
//   load_en    program-load write enable
//   load_idx   program-load word index
//   load_data  program-load word
//   fetch_cnt  accepted-request count, wraps modulo 2^32
// Parameters:
//   DEPTH    words in the array, power of two (>= 2)
//   BASE     byte address of word 0
//   LATENCY  handshake-to-rvalid latency in cycles, 1..15
module ysyx_23060191_isram_resp #(
  parameter int          DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  ysyx_23060191_isram_resp_if.slave bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  output logic [31:0]              fetch_cnt
);

  localparam int AW = $clog2(DEPTH);
  // One past the last valid byte address, kept 33 bits wide so that a
  // window ending at 2^32 does not wrap to zero.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rvalid_q;
  logic [31:0] fetch_cnt_q;

  logic [31:0] mem_q [DEPTH];

  logic          arready;
  logic          hs;
  logic [31:0]   cap_addr;
  logic          cap_misalign;
  logic          cap_oor;
  logic [1:0]    cap_resp;
  logic [AW-1:0] cap_idx;

  assign arready = rstn & (state_q == IDLE);
  assign hs      = bus.arvalid & arready;

  // Address used when entering RESP. With LATENCY == 1 the entry happens on
  // the handshake edge itself, so the incoming araddr is the latched value.
  always_comb begin
    cap_addr     = (state_q == IDLE) ? bus.araddr : addr_q;
    cap_misalign = |cap_addr[1:0];
    cap_oor      = ({1'b0, cap_addr} < {1'b0, BASE}) || ({1'b0, cap_addr} >= LIMIT);
    cap_idx      = AW'((cap_addr - BASE) >> 2);
    cap_resp     = 2'b00;
    if (cap_misalign)  cap_resp = 2'b10;
    else if (cap_oor)  cap_resp = 2'b11;
  end

  // Program-load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_idx] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rvalid_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            addr_q      <= bus.araddr;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (LATENCY == 1) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= cap_resp;
              rdata_q  <= (cap_resp == 2'b00) ? mem_q[cap_idx] : '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            // Array read at this edge: a same-edge load is not yet visible.
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rresp_q  <= cap_resp;
            rdata_q  <= (cap_resp == 2'b00) ? mem_q[cap_idx] : '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rready) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.arready = arready;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060191_isram_resp.sv
module tb_ysyx_23060191_isram_resp;

  logic        clk;
  logic        rstn;
  logic        load_en;
  logic [11:0] load_idx;
  logic [31:0] load_data;
  logic [31:0] fcnt1;
  logic [31:0] fcnt3;

  int passed;
  int failed;
  int total;

  ysyx_23060191_isram_resp_if b1 ();
  ysyx_23060191_isram_resp_if b3 ();

  ysyx_23060191_isram_resp #(.DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .bus(b1),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .fetch_cnt(fcnt1)
  );

  ysyx_23060191_isram_resp #(.DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(3)) u3 (
    .clk(clk), .rstn(rstn), .bus(b3),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .fetch_cnt(fcnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = 12'(idx);
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  // Single fetch on the LATENCY=1 instance with rready tied high.
  task automatic fetch1(input string tag, input logic [31:0] addr,
                        input logic [1:0] resp, input logic [31:0] data);
    b1.arvalid = 1'b1;
    b1.araddr  = addr;
    b1.rready  = 1'b1;
    step();
    b1.arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(b1.rvalid), 32'd1);
    chk({tag, "_rresp"},  32'(b1.rresp),  32'(resp));
    chk({tag, "_rdata"},  b1.rdata,       data);
    $display("txn %s addr=%h rresp=%b rdata=%h", tag, addr, b1.rresp, b1.rdata);
    step();
    chk({tag, "_done"},   32'(b1.rvalid), 32'd0);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rstn = 1'b0;
    load_en = 1'b0; load_idx = '0; load_data = '0;
    b1.arvalid = 1'b0; b1.araddr = '0; b1.rready = 1'b0;
    b3.arvalid = 1'b0; b3.araddr = '0; b3.rready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_arready1", 32'(b1.arready), 32'd0);
    chk("rst_rvalid1",  32'(b1.rvalid),  32'd0);
    chk("rst_rdata1",   b1.rdata,        32'd0);
    chk("rst_rresp1",   32'(b1.rresp),   32'd0);
    chk("rst_fcnt1",    fcnt1,           32'd0);
    chk("rst_arready3", 32'(b3.arready), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rel_arready1", 32'(b1.arready), 32'd1);
    chk("rel_arready3", 32'(b3.arready), 32'd1);

    load(0,    32'h0000_0413);
    load(1,    32'h0010_0093);
    load(2,    32'h0020_0113);
    load(4095, 32'hCAFE_F00D);

    // Aligned fetch, LATENCY=1
    b1.arvalid = 1'b1; b1.araddr = 32'h8000_0000; b1.rready = 1'b1;
    step();
    b1.arvalid = 1'b0;
    chk("l1_rvalid",  32'(b1.rvalid),  32'd1);
    chk("l1_rdata",   b1.rdata,        32'h0000_0413);
    chk("l1_rresp",   32'(b1.rresp),   32'd0);
    chk("l1_fcnt",    fcnt1,           32'd1);
    chk("l1_arready", 32'(b1.arready), 32'd0);
    $display("txn l1 addr=80000000 rdata=%h", b1.rdata);
    step();
    chk("l1_idle_rvalid",  32'(b1.rvalid),  32'd0);
    chk("l1_idle_arready", 32'(b1.arready), 32'd1);

    // Latency and backpressure, LATENCY=3
    b3.arvalid = 1'b1; b3.araddr = 32'h8000_0004; b3.rready = 1'b0;
    step();
    b3.arvalid = 1'b0;
    chk("l3_c1_rvalid",  32'(b3.rvalid),  32'd0);
    chk("l3_c1_arready", 32'(b3.arready), 32'd0);
    step();
    chk("l3_c2_rvalid",  32'(b3.rvalid),  32'd0);
    step();
    chk("l3_c3_rvalid",  32'(b3.rvalid),  32'd1);
    chk("l3_rdata",      b3.rdata,        32'h0010_0093);
    chk("l3_rresp",      32'(b3.rresp),   32'd0);
    chk("l3_fcnt",       fcnt3,           32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l3_hold_rvalid",  32'(b3.rvalid),  32'd1);
      chk("l3_hold_rdata",   b3.rdata,        32'h0010_0093);
      chk("l3_hold_rresp",   32'(b3.rresp),   32'd0);
      chk("l3_hold_arready", 32'(b3.arready), 32'd0);
    end
    $display("txn l3 addr=80000004 rdata=%h", b3.rdata);
    b3.rready = 1'b1;
    step();
    chk("l3_done_rvalid",  32'(b3.rvalid),  32'd0);
    chk("l3_done_arready", 32'(b3.arready), 32'd1);

    // Error responses and range boundaries
    fetch1("misalign",  32'h8000_0002, 2'b10, 32'h0);
    fetch1("below",     32'h7FFF_FFFC, 2'b11, 32'h0);
    fetch1("pastend",   32'h8000_4000, 2'b11, 32'h0);
    fetch1("lastword",  32'h8000_3FFC, 2'b00, 32'hCAFE_F00D);
    fetch1("priority",  32'hFFFF_FFFE, 2'b10, 32'h0);
    chk("err_fcnt", fcnt1, 32'd6);

    // Load during WAIT is visible to the capture
    b3.arvalid = 1'b1; b3.araddr = 32'h8000_0004; b3.rready = 1'b0;
    step();
    b3.arvalid = 1'b0;
    load(1, 32'hDEAD_BEEF);
    step();
    chk("ldwait_rvalid", 32'(b3.rvalid), 32'd1);
    chk("ldwait_rdata",  b3.rdata,       32'hDEAD_BEEF);
    $display("txn ldwait addr=80000004 rdata=%h", b3.rdata);
    b3.rready = 1'b1;
    step();
    chk("ldwait_done", 32'(b3.rvalid), 32'd0);

    // Load on the RESP-entry edge is not visible; held response unchanged
    b3.arvalid = 1'b1; b3.araddr = 32'h8000_0008; b3.rready = 1'b0;
    step();
    b3.arvalid = 1'b0;
    step();
    load(2, 32'h1111_1111);
    chk("ldedge_rvalid", 32'(b3.rvalid), 32'd1);
    chk("ldedge_rdata",  b3.rdata,       32'h0020_0113);
    step();
    chk("ldedge_hold",   b3.rdata,       32'h0020_0113);
    $display("txn ldedge addr=80000008 rdata=%h", b3.rdata);
    b3.rready = 1'b1;
    step();
    chk("ldedge_done", 32'(b3.rvalid), 32'd0);
    fetch1("ldnew", 32'h8000_0008, 2'b00, 32'h1111_1111);

    // Reset in the middle of a transaction
    b3.arvalid = 1'b1; b3.araddr = 32'h8000_0000; b3.rready = 1'b1;
    step();
    b3.arvalid = 1'b0;
    chk("mid_wait_arready", 32'(b3.arready), 32'd0);
    rstn = 1'b0;
    step();
    chk("mid_rst_arready", 32'(b3.arready), 32'd0);
    chk("mid_rst_rvalid",  32'(b3.rvalid),  32'd0);
    chk("mid_rst_fcnt3",   fcnt3,           32'd0);
    chk("mid_rst_fcnt1",   fcnt1,           32'd0);
    rstn = 1'b1;
    #1;
    chk("mid_rel_arready", 32'(b3.arready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_rvalid", 32'(b3.rvalid), 32'd0);
    end

    // Back-to-back stream, LATENCY=1, rready high
    for (int i = 0; i < 100; i++) load(i, 32'h1000_0000 + 32'(i) * 32'd3);
    b1.rready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b1.arvalid = 1'b1;
      b1.araddr  = 32'h8000_0000 + 32'(i) * 32'd4;
      step();
      chk("strm_rvalid", 32'(b1.rvalid), 32'd1);
      chk("strm_rdata",  b1.rdata,       32'h1000_0000 + 32'(i) * 32'd3);
      $display("txn strm %0d addr=%h rdata=%h", i, b1.araddr, b1.rdata);
      step();
      chk("strm_gap", 32'(b1.rvalid), 32'd0);
    end
    b1.arvalid = 1'b0;
    chk("strm_fcnt", fcnt1, 32'd100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
